sd_crc_16: RTL and testbench
============================

// Module: sd_crc_16
// PURPOSE
// - Serial CRC-16 generator/checker for one SD data line (SD spec CRC16, poly x^16+x^12+x^5+1).
// - One instance per DAT line in the SD data serial host; consumes one bit per sd_clk when enabled.
// - Host drives bit/enable/clear on the falling edge; this block samples on the rising edge.
// - CRC register is read directly by the host for transmit (MSB first) and for receive comparison.
// PARAMETERS
// - CRC_W   16       CRC register width
// - POLY    16'h1021 generator polynomial, implicit x^16 term omitted
// - INIT    16'h0000 value loaded by reset and by clear
// PORTS
// - sd_clk   in   1      bit clock; all state updates on rising edge
// - rst_n    in   1      asynchronous active-low reset
// - bitval   in   1      serial data bit, MSB of each data word first
// - enable   in   1      1 = shift bitval into CRC this cycle; 0 = hold
// - clear    in   1      synchronous active-high clear to INIT (host crc_rst)
// - crc      out  CRC_W  current CRC remainder, registered
// BEHAVIOUR
// - Reset: rst_n=0 forces crc=INIT immediately, independent of sd_clk; holds while low.
// - Priority at rising edge: clear > enable > hold.
// - clear=1: crc <= INIT, regardless of enable and bitval.
// - enable=1, clear=0: fb = bitval ^ crc[CRC_W-1]; crc <= {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
// - Default poly expands to: crc[0]<=fb; crc[5]<=crc[4]^fb; crc[12]<=crc[11]^fb; other bits crc[i]<=crc[i-1].
// - enable=0, clear=0: crc unchanged.
// - Latency: crc reflects a bit one rising edge after it is sampled; no combinational input-to-output path.
// - No final XOR or bit reflection; output is raw remainder (init 0, non-reflected CCITT/XMODEM form).
// - Appending the 16 CRC bits (MSB first) to the data and continuing to shift yields crc=0.
// - Reset mid-stream: all accumulated state lost, crc=INIT; next enabled bit starts a fresh CRC.
// - clear held for many cycles: crc stays INIT; first enabled cycle after clear falls starts accumulation.
// - X/Z on bitval while enable=0 must not affect crc.
// STRUCTURE
// - Single flat module, one always block (async reset, sync clear/enable) plus feedback logic.
// - Shared package sd_defines: SD_CRC16_POLY=16'h1021, SD_CRC16_W=16 for host and this block.
// - Feedback computed generically from POLY via generate loop; no sub-module.
// - Host instantiates SD_BUS_W copies with shared enable/clear, one bitval per DAT line.
// TESTING
// - Reset: rst_n=0 asynchronously between clock edges -> crc=16'h0000 without a clock edge.
// - Single bit: clear, then one enabled bit '1' -> crc=16'h1021; next enabled bit '0' -> crc=16'h2042.
// - ASCII "123456789" MSB-first, enable every cycle, 72 bits -> crc=16'h31C3.
// - 512 bytes of 8'hFF (4096 one-bits) -> crc=16'h7FA1 (SD spec example).
// - Hold/priority: enable=0 with toggling bitval -> crc unchanged; clear=1 with enable=1 -> crc=0.
// - Self-check: data "123456789" followed by 16'h31C3 MSB-first -> crc=16'h0000.

Source files
------------

// File: rtl/sd_crc_16_pkg.sv
// Shared SD data-path constants used by the host and the per-line CRC-16 blocks.
package sd_defines;

  localparam int unsigned     SD_CRC16_W    = 16;
  localparam logic [15:0]     SD_CRC16_POLY = 16'h1021;
  localparam logic [15:0]     SD_CRC16_INIT = 16'h0000;

endpackage : sd_defines

// File: rtl/sd_crc_16.sv
// Serial CRC-16 (x^16+x^12+x^5+1) generator/checker for one SD DAT line.
// One bit is absorbed per rising sd_clk while enable is high; clear has priority.
// The remainder is raw (no final XOR, no reflection) and is read MSB first by the host.
module sd_crc_16
  import sd_defines::*;
#(
  parameter int unsigned       CRC_W = SD_CRC16_W,
  parameter logic [CRC_W-1:0]  POLY  = SD_CRC16_POLY,
  parameter logic [CRC_W-1:0]  INIT  = SD_CRC16_INIT
) (
  input  logic             sd_clk,
  input  logic             rst_n,
  input  logic             bitval,
  input  logic             enable,
  input  logic             clear,
  output logic [CRC_W-1:0] crc
);

  logic             fb;
  logic [CRC_W-1:0] crc_next;

  assign fb = bitval ^ crc[CRC_W-1];

  // Shift-and-conditionally-xor, expanded bit by bit from POLY so that
  // untapped positions reduce to plain shift wiring.
  genvar gi;
  generate
    for (gi = 0; gi < CRC_W; gi++) begin : g_fb
      if (gi == 0) begin : g_lsb
        assign crc_next[gi] = POLY[gi] & fb;
      end else begin : g_bit
        assign crc_next[gi] = crc[gi-1] ^ (POLY[gi] & fb);
      end
    end
  endgenerate

  // CRC register: async reset, then clear > enable > hold.
  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= INIT;
    end else if (clear) begin
      crc <= INIT;
    end else if (enable) begin
      crc <= crc_next;
    end
  end

endmodule : sd_crc_16

// File: tb/tb_sd_crc_16.sv
// Directed bench for sd_crc_16: reset, single bits, check string, SD 0xFF block,
// hold/priority, residue self-check, mid-stream reset and long clear.
module tb_sd_crc_16;

  logic        sd_clk;
  logic        rst_n;
  logic        bitval;
  logic        enable;
  logic        clear;
  logic [15:0] crc;

  int vectors;
  int errors;

  sd_crc_16 #(.CRC_W(16), .POLY(16'h1021), .INIT(16'h0000)) dut (
    .sd_clk (sd_clk),
    .rst_n  (rst_n),
    .bitval (bitval),
    .enable (enable),
    .clear  (clear),
    .crc    (crc)
  );

  initial sd_clk = 1'b0;
  always #5 sd_clk = ~sd_clk;

  // Drive one enabled bit on the falling edge; return just after the rising edge.
  task automatic shift_bit(input logic b);
    @(negedge sd_clk);
    bitval = b;
    enable = 1'b1;
    clear  = 1'b0;
    @(posedge sd_clk);
    #1;
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) shift_bit(b[i]);
  endtask

  task automatic go_idle();
    @(negedge sd_clk);
    enable = 1'b0;
    clear  = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge sd_clk);
    clear  = 1'b1;
    enable = 1'b0;
    @(posedge sd_clk);
    #1;
    @(negedge sd_clk);
    clear = 1'b0;
  endtask

  task automatic shift_check_string();
    logic [7:0] s [9];
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int i = 0; i < 9; i++) shift_byte(s[i]);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    bitval = 1'b0;
    enable = 1'b0;
    clear  = 1'b0;
    #2;
    vectors++;
    if (crc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_initial: crc=%h expected=%h", crc, 16'h0000);
    end
    @(negedge sd_clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_bit();
    do_clear();
    // Drive a '1' and confirm nothing moves before the rising edge.
    bitval = 1'b1;
    enable = 1'b1;
    #1;
    vectors++;
    if (crc !== 16'h0000) begin
      errors++;
      $display("FAIL no_comb_path: crc=%h expected=%h", crc, 16'h0000);
    end
    @(posedge sd_clk);
    #1;
    vectors++;
    if (crc !== 16'h1021) begin
      errors++;
      $display("FAIL single_bit_1: crc=%h expected=%h", crc, 16'h1021);
    end
    shift_bit(1'b0);
    vectors++;
    if (crc !== 16'h2042) begin
      errors++;
      $display("FAIL single_bit_0: crc=%h expected=%h", crc, 16'h2042);
    end
    go_idle();
  endtask

  task automatic test_check_string();
    do_clear();
    shift_check_string();
    vectors++;
    if (crc !== 16'h31C3) begin
      errors++;
      $display("FAIL check_string: crc=%h expected=%h", crc, 16'h31C3);
    end
  endtask

  // Runs straight after test_check_string with the 0x31C3 remainder still held.
  task automatic test_hold_priority();
    go_idle();
    for (int i = 0; i < 8; i++) begin
      @(negedge sd_clk);
      bitval = (i == 3) ? 1'bx : ((i % 2) == 0 ? 1'b1 : 1'b0);
    end
    @(posedge sd_clk);
    #1;
    vectors++;
    if (crc !== 16'h31C3) begin
      errors++;
      $display("FAIL hold: crc=%h expected=%h", crc, 16'h31C3);
    end
    @(negedge sd_clk);
    bitval = 1'b1;
    enable = 1'b1;
    clear  = 1'b1;
    @(posedge sd_clk);
    #1;
    vectors++;
    if (crc !== 16'h0000) begin
      errors++;
      $display("FAIL clear_over_enable: crc=%h expected=%h", crc, 16'h0000);
    end
    go_idle();
  endtask

  task automatic test_ff_block();
    do_clear();
    for (int i = 0; i < 4096; i++) shift_bit(1'b1);
    vectors++;
    if (crc !== 16'h7FA1) begin
      errors++;
      $display("FAIL ff_block: crc=%h expected=%h", crc, 16'h7FA1);
    end
    go_idle();
  endtask

  task automatic test_self_check();
    logic [15:0] r;
    r = 16'h31C3;
    do_clear();
    shift_check_string();
    for (int i = 15; i >= 0; i--) shift_bit(r[i]);
    vectors++;
    if (crc !== 16'h0000) begin
      errors++;
      $display("FAIL residue: crc=%h expected=%h", crc, 16'h0000);
    end
    go_idle();
  endtask

  task automatic test_reset_midstream();
    do_clear();
    shift_byte(8'hA5);
    shift_byte(8'h3C);
    go_idle();
    vectors++;
    if (crc === 16'h0000) begin
      errors++;
      $display("FAIL midstream_nonzero: crc=%h expected nonzero", crc);
    end
    // Assert reset away from any rising edge and check it takes effect at once.
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (crc !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: crc=%h expected=%h", crc, 16'h0000);
    end
    @(negedge sd_clk);
    rst_n = 1'b1;
    shift_bit(1'b1);
    vectors++;
    if (crc !== 16'h1021) begin
      errors++;
      $display("FAIL after_reset_bit: crc=%h expected=%h", crc, 16'h1021);
    end
    go_idle();
  endtask

  task automatic test_clear_held();
    do_clear();
    shift_byte(8'hC3);
    @(negedge sd_clk);
    clear  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sd_clk);
      bitval = i[0];
    end
    #1;
    vectors++;
    if (crc !== 16'h0000) begin
      errors++;
      $display("FAIL clear_held: crc=%h expected=%h", crc, 16'h0000);
    end
    clear  = 1'b0;
    bitval = 1'b1;
    @(posedge sd_clk);
    #1;
    vectors++;
    if (crc !== 16'h1021) begin
      errors++;
      $display("FAIL first_after_clear: crc=%h expected=%h", crc, 16'h1021);
    end
    shift_bit(1'b1);
    vectors++;
    if (crc !== 16'h3063) begin
      errors++;
      $display("FAIL second_after_clear: crc=%h expected=%h", crc, 16'h3063);
    end
    go_idle();
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_single_bit();
    test_check_string();
    test_hold_priority();
    test_ff_block();
    test_self_check();
    test_reset_midstream();
    test_clear_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_sd_crc_16
